reorder_buff_mc: RTL and testbench

Parametrised in-order commit buffer for the vector lane backend, successor to the single-lane four-source vector reorder buffer. It records issued instruction numbers in program order and collects out-of-order completion reports from `NUM_CH` execution channels (LdSt, Math, Move, and any extra units). It retires entries strictly in order to the hazard unit through a req/grant handshake, and supports flush and slice-stall signalling.

---
 rtl/reorder_buff_mc_if.sv | 35 +++
 rtl/reorder_buff_mc.sv | 113 +++++++++++
 tb/tb_reorder_buff_mc.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buff_mc_if.sv
// rtl/reorder_buff_mc_if.sv - issue/completion/retire bundle of the multi-channel in-order commit buffer
interface reorder_buff_mc_if #(
  parameter int NUM_ENTRY = 16,
  parameter int NUM_CH    = 4,
  parameter int WIDTH_NO  = 7
);
  localparam int CNT_W = $clog2(NUM_ENTRY) + 1;

  logic                         I_En_Lane;
  logic                         I_Flush;
  logic                         I_Store;
  logic [WIDTH_NO-1:0]          I_Issue_No;
  logic                         I_Slice;
  logic [NUM_CH-1:0]            I_Commit_Req;
  logic [NUM_CH*WIDTH_NO-1:0]   I_Commit_No;
  logic                         I_Commit_Grant;
  logic                         O_Commit_Req;
  logic [WIDTH_NO-1:0]          O_Commit_No;
  logic                         O_Full;
  logic                         O_Empty;
  logic [CNT_W-1:0]             O_Num;
  logic                         O_Stall;

  modport master (
    output I_En_Lane, I_Flush, I_Store, I_Issue_No, I_Slice,
           I_Commit_Req, I_Commit_No, I_Commit_Grant,
    input  O_Commit_Req, O_Commit_No, O_Full, O_Empty, O_Num, O_Stall
  );

  modport slave (
    input  I_En_Lane, I_Flush, I_Store, I_Issue_No, I_Slice,
           I_Commit_Req, I_Commit_No, I_Commit_Grant,
    output O_Commit_Req, O_Commit_No, O_Full, O_Empty, O_Num, O_Stall
  );
endinterface

// File: rtl/reorder_buff_mc.sv
// rtl/reorder_buff_mc.sv - in-order commit buffer collecting out-of-order completions from NUM_CH channels
// Define REORDERBUFF_MC_BYPASS_EN for a same-cycle completion-to-request path on the head entry.
module reorder_buff_mc #(
  parameter int NUM_ENTRY = 16,
  parameter int NUM_CH    = 4,
  parameter int WIDTH_NO  = 7
) (
  input  logic            clock,
  input  logic            reset,
  reorder_buff_mc_if.slave rob
);
  localparam int PW = $clog2(NUM_ENTRY);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(NUM_ENTRY);

  logic [NUM_ENTRY-1:0] v_q;
  logic [NUM_ENTRY-1:0] done_q;
  logic [NUM_ENTRY-1:0] slice_q;
  logic [WIDTH_NO-1:0]  no_q [NUM_ENTRY];
  logic [PW-1:0]        rno_q;
  logic [PW-1:0]        wno_q;
  logic [PW:0]          num_q;

  logic [NUM_ENTRY-1:0] hit;
  logic                 head_done;
  logic                 commit_req;
  logic                 full;
  logic                 we;
  logic                 re;
  logic                 stall;

  // An entry is hit when any channel reports its number; duplicates all match.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_ENTRY; i++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (rob.I_Commit_Req[k] && (rob.I_Commit_No[k*WIDTH_NO +: WIDTH_NO] == no_q[i]))
          hit[i] = 1'b1;
      end
    end
  end

`ifdef REORDERBUFF_MC_BYPASS_EN
  assign head_done = done_q[rno_q] | hit[rno_q];
`else
  assign head_done = done_q[rno_q];
`endif

  assign commit_req = v_q[rno_q] & head_done & rob.I_En_Lane;
  assign full       = (num_q == FULL_CNT);
  assign we         = rob.I_Store & ~full & ~rob.I_Flush;
  assign re         = commit_req & rob.I_Commit_Grant & ~rob.I_Flush;

  always_comb begin
    stall = 1'b0;
    for (int i = 0; i < NUM_ENTRY; i++) begin
      if ((rno_q != PW'(i)) && v_q[i] && slice_q[i])
        stall = 1'b1;
    end
  end

  // Retire clear precedes completion set, and the push write lands last.
  always_ff @(posedge clock) begin
    if (reset) begin
      v_q     <= '0;
      done_q  <= '0;
      slice_q <= '0;
      rno_q   <= '0;
      wno_q   <= '0;
      num_q   <= '0;
      for (int i = 0; i < NUM_ENTRY; i++)
        no_q[i] <= '0;
    end else if (rob.I_Flush) begin
      v_q     <= '0;
      done_q  <= '0;
      slice_q <= '0;
      rno_q   <= '0;
      wno_q   <= '0;
      num_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRY; i++) begin
        if (re && (rno_q == PW'(i))) begin
          v_q[i]     <= 1'b0;
          done_q[i]  <= 1'b0;
          slice_q[i] <= 1'b0;
        end else if (v_q[i] && hit[i]) begin
          done_q[i] <= 1'b1;
        end
        if (we && (wno_q == PW'(i))) begin
          v_q[i]     <= 1'b1;
          done_q[i]  <= 1'b0;
          slice_q[i] <= rob.I_Slice;
          no_q[i]    <= rob.I_Issue_No;
        end
      end
      if (re)
        rno_q <= rno_q + 1'b1;
      if (we)
        wno_q <= wno_q + 1'b1;
      case ({we, re})
        2'b10:   num_q <= num_q + 1'b1;
        2'b01:   num_q <= num_q - 1'b1;
        default: num_q <= num_q;
      endcase
    end
  end

  assign rob.O_Commit_Req = commit_req;
  assign rob.O_Commit_No  = no_q[rno_q];
  assign rob.O_Full       = full;
  assign rob.O_Empty      = (num_q == '0);
  assign rob.O_Num        = num_q;
  assign rob.O_Stall      = stall;
endmodule

// File: tb/tb_reorder_buff_mc.sv
// tb/tb_reorder_buff_mc.sv - vector table, corner sequences and random run against a queue model
module tb_reorder_buff_mc;
  localparam int N  = 16;
  localparam int CH = 4;
  localparam int W  = 7;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  reorder_buff_mc_if #(.NUM_ENTRY(N), .NUM_CH(CH), .WIDTH_NO(W)) bus ();

  reorder_buff_mc #(.NUM_ENTRY(N), .NUM_CH(CH), .WIDTH_NO(W)) dut (
    .clock (clock),
    .reset (reset),
    .rob   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic         st;
    logic [W-1:0] ino;
    logic         sl;
    logic [CH-1:0] cr;
    logic [CH*W-1:0] cn;
    logic         gr;
    logic         en;
    int           num;
    logic         req;
    logic         byp_req;
    logic [W-1:0] no;
    logic         stall;
  } vec_t;

  typedef struct {
    logic [W-1:0] no;
    logic         done;
    logic         slice;
  } ent_t;

  ent_t q[$];
  vec_t tbl[23];

  function automatic vec_t mk(logic st, int ino, logic sl, logic [CH-1:0] cr, logic [CH*W-1:0] cn,
                              logic gr, logic en, int num, logic req, logic byp, int no, logic stall);
    vec_t v;
    v.st = st; v.ino = W'(ino); v.sl = sl; v.cr = cr; v.cn = cn; v.gr = gr; v.en = en;
    v.num = num; v.req = req; v.byp_req = byp; v.no = W'(no); v.stall = stall;
    return v;
  endfunction

  function automatic logic [CH*W-1:0] cn_at(int k, int n);
    logic [CH*W-1:0] r;
    r = '0;
    r[k*W +: W] = W'(n);
    return r;
  endfunction

  function automatic logic match(logic [CH-1:0] cr, logic [CH*W-1:0] cn, logic [W-1:0] n);
    for (int k = 0; k < CH; k++)
      if (cr[k] && cn[k*W +: W] == n) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic drive(logic st, logic [W-1:0] ino, logic sl, logic [CH-1:0] cr,
                       logic [CH*W-1:0] cn, logic gr, logic en, logic fl);
    bus.I_Store = st; bus.I_Issue_No = ino; bus.I_Slice = sl;
    bus.I_Commit_Req = cr; bus.I_Commit_No = cn;
    bus.I_Commit_Grant = gr; bus.I_En_Lane = en; bus.I_Flush = fl;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    q.delete();
  endtask

  // One cycle: drive, compare DUT against the model mid-cycle, then advance the model past the edge.
  task automatic cycle(string tag, logic st, logic [W-1:0] ino, logic sl, logic [CH-1:0] cr,
                       logic [CH*W-1:0] cn, logic gr, logic en, logic fl);
    logic exp_req;
    logic exp_stall;
    int   pre;
    drive(st, ino, sl, cr, cn, gr, en, fl);
    #4;
    exp_req = 1'b0;
    if (q.size() > 0 && en) begin
      exp_req = q[0].done;
`ifdef REORDERBUFF_MC_BYPASS_EN
      if (match(cr, cn, q[0].no)) exp_req = 1'b1;
`endif
    end
    exp_stall = 1'b0;
    for (int i = 1; i < q.size(); i++)
      if (q[i].slice) exp_stall = 1'b1;
    chk({tag, "_req"}, int'(bus.O_Commit_Req), int'(exp_req));
    if (exp_req) chk({tag, "_no"}, int'(bus.O_Commit_No), int'(q[0].no));
    chk({tag, "_num"}, int'(bus.O_Num), q.size());
    chk({tag, "_full"}, int'(bus.O_Full), int'(q.size() == N));
    chk({tag, "_empty"}, int'(bus.O_Empty), int'(q.size() == 0));
    chk({tag, "_stall"}, int'(bus.O_Stall), int'(exp_stall));
    @(posedge clock); #1;
    if (fl) begin
      q.delete();
    end else begin
      pre = q.size();
      if (exp_req && gr) void'(q.pop_front());
      foreach (q[i])
        if (match(cr, cn, q[i].no)) q[i].done = 1'b1;
      if (st && pre < N) q.push_back('{no: ino, done: 1'b0, slice: sl});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    chk("rst_req",   int'(bus.O_Commit_Req), 0);
    chk("rst_no",    int'(bus.O_Commit_No), 0);
    chk("rst_full",  int'(bus.O_Full), 0);
    chk("rst_empty", int'(bus.O_Empty), 1);
    chk("rst_num",   int'(bus.O_Num), 0);
    chk("rst_stall", int'(bus.O_Stall), 0);

    //           st ino sl cr      cn                  gr en num req byp no stall
    tbl[0]  = mk(0, 0,  0, 4'b0000, '0,                0, 1, 0, 0, 0, 0,  0);
    tbl[1]  = mk(1, 3,  0, 4'b0000, '0,                0, 1, 0, 0, 0, 0,  0);
    tbl[2]  = mk(1, 5,  0, 4'b0000, '0,                0, 1, 1, 0, 0, 0,  0);
    tbl[3]  = mk(1, 9,  0, 4'b0000, '0,                0, 1, 2, 0, 0, 0,  0);
    tbl[4]  = mk(0, 0,  0, 4'b0100, cn_at(2, 9),       0, 1, 3, 0, 0, 0,  0);
    tbl[5]  = mk(0, 0,  0, 4'b0010, cn_at(1, 5),       0, 1, 3, 0, 0, 0,  0);
    tbl[6]  = mk(0, 0,  0, 4'b0001, cn_at(0, 3),       0, 1, 3, 0, 1, 3,  0);
    tbl[7]  = mk(0, 0,  0, 4'b0000, '0,                1, 1, 3, 1, 1, 3,  0);
    tbl[8]  = mk(0, 0,  0, 4'b0000, '0,                1, 1, 2, 1, 1, 5,  0);
    tbl[9]  = mk(0, 0,  0, 4'b0000, '0,                1, 1, 1, 1, 1, 9,  0);
    tbl[10] = mk(1, 7,  0, 4'b0000, '0,                0, 1, 0, 0, 0, 0,  0);
    tbl[11] = mk(1, 8,  0, 4'b0000, '0,                0, 1, 1, 0, 0, 0,  0);
    tbl[12] = mk(0, 0,  0, 4'b1111, {4{7'd7}},         0, 1, 2, 0, 1, 7,  0);
    tbl[13] = mk(0, 0,  0, 4'b0000, '0,                1, 1, 2, 1, 1, 7,  0);
    tbl[14] = mk(0, 0,  0, 4'b0000, '0,                1, 1, 1, 0, 0, 0,  0);
    tbl[15] = mk(0, 0,  0, 4'b1000, cn_at(3, 8),       0, 1, 1, 0, 1, 8,  0);
    tbl[16] = mk(0, 0,  0, 4'b0000, '0,                1, 0, 1, 0, 0, 0,  0);
    tbl[17] = mk(0, 0,  0, 4'b0000, '0,                1, 1, 1, 1, 1, 8,  0);
    tbl[18] = mk(1, 10, 0, 4'b0000, '0,                0, 1, 0, 0, 0, 0,  0);
    tbl[19] = mk(1, 11, 1, 4'b0000, '0,                0, 1, 1, 0, 0, 0,  0);
    tbl[20] = mk(0, 0,  0, 4'b0001, cn_at(0, 10),      0, 1, 2, 0, 1, 10, 1);
    tbl[21] = mk(0, 0,  0, 4'b0000, '0,                1, 1, 2, 1, 1, 10, 1);
    tbl[22] = mk(0, 0,  0, 4'b0000, '0,                0, 1, 1, 0, 0, 0,  0);

    for (int r = 0; r < 23; r++) begin
      logic er;
      drive(tbl[r].st, tbl[r].ino, tbl[r].sl, tbl[r].cr, tbl[r].cn, tbl[r].gr, tbl[r].en, 1'b0);
      #4;
`ifdef REORDERBUFF_MC_BYPASS_EN
      er = tbl[r].byp_req;
`else
      er = tbl[r].req;
`endif
      chk($sformatf("tbl%0d_req", r), int'(bus.O_Commit_Req), int'(er));
      if (er) chk($sformatf("tbl%0d_no", r), int'(bus.O_Commit_No), int'(tbl[r].no));
      chk($sformatf("tbl%0d_num", r), int'(bus.O_Num), tbl[r].num);
      chk($sformatf("tbl%0d_empty", r), int'(bus.O_Empty), int'(tbl[r].num == 0));
      chk($sformatf("tbl%0d_stall", r), int'(bus.O_Stall), int'(tbl[r].stall));
      @(posedge clock); #1;
    end

    // Fill, overflow drop, retire-then-push wrap, full push+retire, then drain in order.
    do_reset();
    for (int i = 0; i < N; i++) cycle("fill", 1, W'(20 + i), 0, 0, 0, 0, 1, 0);
    cycle("ovf", 1, 7'd99, 0, 0, 0, 0, 1, 0);
    chk("ovf_num", int'(bus.O_Num), 16);
    chk("ovf_full", int'(bus.O_Full), 1);
    cycle("cpl20", 0, 0, 0, 4'b0001, cn_at(0, 20), 0, 1, 0);
    cycle("gr20", 0, 0, 0, 0, 0, 1, 1, 0);
    chk("after_grant_num", int'(bus.O_Num), 15);
    cycle("wrap_push", 1, 7'd77, 0, 0, 0, 0, 1, 0);
    chk("wrap_push_num", int'(bus.O_Num), 16);
    cycle("cpl21", 0, 0, 0, 4'b0010, cn_at(1, 21), 0, 1, 0);
    cycle("full_push_re", 1, 7'd88, 0, 0, 0, 1, 1, 0);
    chk("full_push_re_num", int'(bus.O_Num), 15);
    while (q.size() > 0) begin
      cycle("drain_c", 0, 0, 0, 4'b0100, cn_at(2, int'(q[0].no)), 0, 1, 0);
      cycle("drain_g", 0, 0, 0, 0, 0, 1, 1, 0);
    end
    chk("drain_empty", int'(bus.O_Empty), 1);

    // Flush with five valid entries while a store and a grant are also raised.
    do_reset();
    for (int i = 1; i <= 5; i++) cycle("fl_fill", 1, W'(i), 0, 0, 0, 0, 1, 0);
    cycle("fl_cpl", 0, 0, 0, 4'b0001, cn_at(0, 1), 0, 1, 0);
    cycle("fl", 1, 7'd50, 0, 0, 0, 1, 1, 1);
    chk("fl_empty", int'(bus.O_Empty), 1);
    chk("fl_num", int'(bus.O_Num), 0);
    chk("fl_req", int'(bus.O_Commit_Req), 0);
    cycle("fl_after", 0, 0, 0, 0, 0, 0, 1, 0);

    // Reset while a granted request is pending abandons it.
    cycle("rh_p", 1, 7'd4, 0, 0, 0, 0, 1, 0);
    cycle("rh_c", 0, 0, 0, 4'b0001, cn_at(0, 4), 0, 1, 0);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 1, 1, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    q.delete();
    chk("rh_num", int'(bus.O_Num), 0);
    chk("rh_req", int'(bus.O_Commit_Req), 0);

    for (int c = 0; c < 3000; c++) begin
      logic [CH*W-1:0] cn;
      for (int k = 0; k < CH; k++) cn[k*W +: W] = W'($urandom_range(0, 7));
      cycle("rnd",
            logic'($urandom_range(0, 9) < 6),
            W'($urandom_range(0, 7)),
            logic'($urandom_range(0, 3) == 0),
            CH'($urandom),
            cn,
            logic'($urandom_range(0, 9) < 7),
            logic'($urandom_range(0, 9) != 0),
            logic'($urandom_range(0, 49) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
